ex_div_ctrl: RTL

EX_DIV_CTRL -- requirements
Module: ex_div_ctrl

---
 rtl/ex_div_ctrl.sv | 99 +++++++++
 1 files changed

// File: rtl/ex_div_ctrl.sv
// EX-stage divide controller: hands a DIV/DIVU to a multi-cycle divider, stalls the pipe, writes HI/LO once.
// Optional build macro DIV_ZERO_SKIP_EN: a zero divisor bypasses the divider (hi = dividend, lo = all ones).
module ex_div_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  op_i,
   input  logic [31:0] rs_data_i,
   input  logic [31:0] rt_data_i,
   input  logic        valid_i,
   input  logic        advance_i,
   input  logic        flush_i,
   output logic [4:0]  div_op_o,
   output logic [31:0] div_op1_o,
   output logic [31:0] div_op2_o,
   output logic        div_start_o,
   output logic        div_annul_o,
   input  logic [63:0] div_result_i,
   input  logic        div_ready_i,
   output logic        stall_req_o,
   output logic        hilo_we_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   localparam logic [4:0] DIV_CONTROL  = 5'b11010;
   localparam logic [4:0] DIVU_CONTROL = 5'b11011;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t state_reg;
   logic   first_reg;
   logic   is_div;
   logic   accept;
   logic   zero_skip;

   assign is_div = (op_i == DIV_CONTROL) || (op_i == DIVU_CONTROL);
   // rst gates acceptance so stall_req_o is held low while reset is asserted
   assign accept = rst && (state_reg == IDLE) && valid_i && is_div && !flush_i;

`ifdef DIV_ZERO_SKIP_EN
   assign zero_skip = (rt_data_i == 32'd0);
`else
   assign zero_skip = 1'b0;
`endif

   always_comb begin
      div_start_o = (state_reg == RUN) && !flush_i;
      div_annul_o = (state_reg == RUN) && flush_i;
      stall_req_o = accept || ((state_reg == RUN) && !flush_i);
      hilo_we_o   = (state_reg == DONE) && first_reg && !flush_i;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         first_reg <= 1'b0;
         div_op_o  <= 5'd0;
         div_op1_o <= 32'd0;
         div_op2_o <= 32'd0;
         hi_o      <= 32'd0;
         lo_o      <= 32'd0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  div_op_o  <= op_i;
                  div_op1_o <= rs_data_i;
                  div_op2_o <= rt_data_i;
                  if (zero_skip) begin
                     hi_o      <= rs_data_i;
                     lo_o      <= 32'hFFFF_FFFF;
                     first_reg <= 1'b1;
                     state_reg <= DONE;
                  end else begin
                     state_reg <= RUN;
                  end
               end
            end
            RUN: begin
               // flush wins over a simultaneous ready: the result is dropped
               if (flush_i) begin
                  state_reg <= IDLE;
               end else if (div_ready_i) begin
                  hi_o      <= div_result_i[63:32];
                  lo_o      <= div_result_i[31:0];
                  first_reg <= 1'b1;
                  state_reg <= DONE;
               end
            end
            DONE: begin
               first_reg <= 1'b0;
               if (advance_i || flush_i) state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
